// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmitter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

  // Frame sequencer states; PARITY is only reachable when UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-request / line-status bundle between a byte producer and the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: producer holds start until busy is seen; requests while busy are dropped.
interface uart_transmitter_if;
  import uart_pkg::*;

  logic                 en;
  logic                 start;
  logic [DATA_BITS-1:0] data_in;
  logic                 busy;
  logic                 done;
  logic                 out;

  modport master (output en, output start, output data_in,
                  input  busy, input done, input out);
  modport slave  (input  en, input start, input data_in,
                  output busy, output done, output out);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: bit_tick_o is combinational from the counter register.
// Backpressure: none; clr_i holds the counter at zero (idle or abort).
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic bit_tick_o
);
  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick_o = !clr_i && (cnt_q == LAST);

  // Free-run within a bit, wrap on the last cycle, park at zero when cleared.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || bit_tick_o) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter, 8N1 LSB first; UART_TX_PARITY_EN inserts an even-parity bit (8E1).
// Latency: line goes low the cycle after an accepted start; all outputs registered.
// Backpressure: start sampled only in IDLE with en high; requests during a frame are dropped.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_transmitter_if.slave  tx_if
);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0]           idx_q, idx_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_tick;

  // Bit timer is held clear while idle or when the enable drops so every bit starts fresh.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      ((state_q == IDLE) || !tx_if.en),
    .bit_tick_o (bit_tick)
  );

  // Next-state and next-output: the output registers take the level of the state being entered.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (!tx_if.en) begin
      state_d = IDLE;
      idx_d   = '0;
      out_d   = IDLE_LEVEL;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_d  = IDLE_LEVEL;
          busy_d = 1'b0;
          if (tx_if.start) begin
            state_d = START;
            data_d  = tx_if.data_in;
            idx_d   = '0;
            out_d   = START_LEVEL;
            busy_d  = 1'b1;
          end
        end
        START: if (bit_tick) begin
          state_d = DATA;
          out_d   = data_q[0];
        end
        DATA: if (bit_tick) begin
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            out_d   = ^data_q;
`else
            state_d = STOP;
            out_d   = STOP_LEVEL;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            out_d = data_q[idx_q + 3'd1];
          end
        end
        PARITY: if (bit_tick) begin
          state_d = STOP;
          out_d   = STOP_LEVEL;
        end
        STOP: if (bit_tick) begin
          state_d = IDLE;
          out_d   = IDLE_LEVEL;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
          out_d   = IDLE_LEVEL;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, frame data and registered outputs; reset returns the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      out_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_if.out  = out_q;
  assign tx_if.busy = busy_q;
  assign tx_if.done = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with CLKS_PER_BIT=4; line sampled mid-bit.
// Frames come from a vector table; abort, back-to-back and async reset are hand sequences.
// Honours UART_TX_PARITY_EN for frame length and expected line patterns.
module tb_uart_transmitter;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  // Line patterns in time order (first bit is the MSB): start, data LSB first, parity, stop.
  localparam logic [10:0] SEQ_AA = 11'b00101010101;
  localparam logic [10:0] SEQ_55 = 11'b01010101001;
  localparam logic [10:0] SEQ_07 = 11'b01110000011;
  localparam logic [10:0] SEQ_00 = 11'b00000000001;
  localparam logic [10:0] SEQ_FF = 11'b01111111101;
  localparam logic [10:0] SEQ_01 = 11'b01000000011;
  localparam logic [10:0] SEQ_80 = 11'b00000000111;
  localparam logic [10:0] SEQ_F0 = 11'b00000111101;
`else
  localparam int NB = 10;
  // Line patterns in time order (first bit is the MSB): start, data LSB first, stop.
  localparam logic [10:0] SEQ_AA = {1'b0, 10'b0010101011};
  localparam logic [10:0] SEQ_55 = {1'b0, 10'b0101010101};
  localparam logic [10:0] SEQ_07 = {1'b0, 10'b0111000001};
  localparam logic [10:0] SEQ_00 = {1'b0, 10'b0000000001};
  localparam logic [10:0] SEQ_FF = {1'b0, 10'b0111111111};
  localparam logic [10:0] SEQ_01 = {1'b0, 10'b0100000001};
  localparam logic [10:0] SEQ_80 = {1'b0, 10'b0000000011};
  localparam logic [10:0] SEQ_F0 = {1'b0, 10'b0000011111};
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;
  int   done_total = 0;
  int   done_expected = 0;

  uart_transmitter_if tif ();

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (tif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tif.done === 1'b1) done_total++;

  typedef struct {
    logic [7:0]  data;
    int          hold;
    int          gap;
    logic [10:0] seq;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start with byte d, hold it for 'hold' edges, watch the whole frame and stop on the done cycle.
  task automatic send_frame(input string nm, input logic [7:0] d, input int hold,
                            input logic [10:0] seq);
    int          busy_cnt = 0;
    int          done_pos = -1;
    logic [10:0] got = '1;
    tif.data_in = d;
    tif.start   = 1'b1;
    step();
    tif.data_in = ~d;
    for (int c = 0; c <= NB * CPB; c++) begin
      if (tif.busy === 1'b1) busy_cnt++;
      if (tif.done === 1'b1 && done_pos < 0) done_pos = c;
      if (c < NB * CPB && (c % CPB) == CPB / 2) got[NB - 1 - c / CPB] = tif.out;
      if (c + 1 == hold) tif.start = 1'b0;
      if (c < NB * CPB) step();
    end
    for (int k = 0; k < NB; k++)
      check($sformatf("%s bit%0d", nm, k), {31'd0, got[NB - 1 - k]}, {31'd0, seq[NB - 1 - k]});
    check($sformatf("%s busy_cycles", nm), busy_cnt, NB * CPB);
    check($sformatf("%s done_pos", nm), done_pos, NB * CPB);
    done_expected++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    vecs[0] = '{data: 8'hAA, hold: 2, gap: 0, seq: SEQ_AA};
    vecs[1] = '{data: 8'hAA, hold: 1, gap: 4, seq: SEQ_AA};
    vecs[2] = '{data: 8'h07, hold: 1, gap: 1, seq: SEQ_07};
    vecs[3] = '{data: 8'h00, hold: 1, gap: 1, seq: SEQ_00};
    vecs[4] = '{data: 8'hFF, hold: 1, gap: 1, seq: SEQ_FF};
    vecs[5] = '{data: 8'h01, hold: 1, gap: 1, seq: SEQ_01};
    vecs[6] = '{data: 8'h80, hold: 1, gap: 1, seq: SEQ_80};

    rst_n       = 1'b1;
    tif.en      = 1'b0;
    tif.start   = 1'b0;
    tif.data_in = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    check("reset out",  {31'd0, tif.out},  32'd1);
    check("reset busy", {31'd0, tif.busy}, 32'd0);
    check("reset done", {31'd0, tif.done}, 32'd0);
    #19 rst_n = 1'b1;
    step();

    // Enable low: start must be ignored.
    tif.start = 1'b1;
    tif.data_in = 8'h3C;
    bad = 0;
    repeat (20) begin
      step();
      if (tif.out !== 1'b1 || tif.busy !== 1'b0 || tif.done !== 1'b0) bad++;
    end
    check("en_low_idle", bad, 0);
    tif.start = 1'b0;
    tif.en    = 1'b1;
    step();

    // Table-driven single frames.
    for (int i = 0; i < 7; i++) begin
      repeat (vecs[i].gap) step();
      send_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].hold, vecs[i].seq);
      step();
    end

    // Back-to-back: start held through the done cycle launches the next frame at once.
    send_frame("b2b0", 8'h55, 1000, SEQ_55);
    send_frame("b2b1", 8'h55, 1000, SEQ_55);
    tif.start = 1'b0;
    step();
    check("b2b idle after", {31'd0, tif.busy}, 32'd0);

    // Abort by dropping enable during data bit 3 of 8'hF0.
    tif.data_in = 8'hF0;
    tif.start   = 1'b1;
    step();
    tif.start = 1'b0;
    repeat (17) step();
    check("abort pre out", {31'd0, tif.out}, 32'd0);
    tif.en = 1'b0;
    step();
    check("abort out",  {31'd0, tif.out},  32'd1);
    check("abort busy", {31'd0, tif.busy}, 32'd0);
    check("abort done", {31'd0, tif.done}, 32'd0);
    repeat (5) step();
    tif.en = 1'b1;
    step();
    send_frame("restart", 8'hF0, 1, SEQ_F0);
    step();

    // Asynchronous reset mid-frame.
    tif.data_in = 8'h00;
    tif.start   = 1'b1;
    step();
    tif.start = 1'b0;
    repeat (10) step();
    check("rst pre out", {31'd0, tif.out}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst async out",  {31'd0, tif.out},  32'd1);
    check("rst async busy", {31'd0, tif.busy}, 32'd0);
    check("rst async done", {31'd0, tif.done}, 32'd0);
    #3 rst_n = 1'b1;
    step();
    step();
    check("rst after out",  {31'd0, tif.out},  32'd1);
    check("rst after busy", {31'd0, tif.busy}, 32'd0);

    check("done_total", done_total, done_expected);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
